mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter W, default 8, SHALL set the data width in bits.
REQ-002 Parameter A, default 8, SHALL set the address width in bits; the memory is 2**A entries deep.
REQ-003 Clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 ReqValid  in  1  SHALL indicate that a request is present.
REQ-006 ReqReady  out  1  SHALL indicate that the unit accepts a request this cycle.
REQ-007 ReqOp  in  2  SHALL encode the operation: 00 load, 01 store, 10 copy, 11 fill.
REQ-008 ReqAddr  in  A  SHALL give the load/store address, or the copy/fill destination base.
REQ-009 ReqSrc  in  A  SHALL give the copy source base; it SHALL be ignored for other ops.
REQ-010 ReqLen  in  A  SHALL give the copy/fill byte count (0..2**A-1); it SHALL be ignored for load/store.
REQ-011 ReqData  in  W  SHALL give the store data or fill value.
REQ-012 RespValid  out  1  SHALL pulse for one cycle when an operation completes.
REQ-013 RespData  out  W  SHALL carry the registered load result.
REQ-014 Busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-015 MemAddr  out  A  SHALL drive the data-memory shared address pointer.
REQ-016 MemWriteEn  out  1  SHALL drive the data-memory write enable.
REQ-017 MemWData  out  W  SHALL drive the data-memory write data.
REQ-018 MemRData  in  W  SHALL receive the data-memory combinational read data.

Function
REQ-019 States SHALL be IDLE, LD, ST, CP_RD, CP_WR, FL_WR and DONE; ReqReady SHALL be 1 only in IDLE.
REQ-020 Acceptance SHALL occur on ReqValid & ReqReady in cycle T; all request fields SHALL be registered on that cycle.
REQ-021 Load SHALL be LD at T+1 (MemAddr=addr, MemRData captured into RespData), then DONE at T+2.
REQ-022 Store SHALL be ST at T+1 (MemAddr=addr, MemWriteEn=1, MemWData=data), then DONE at T+2.
REQ-023 Copy of N>0 bytes SHALL alternate CP_RD (MemAddr=src+i, capture into byte buffer) and CP_WR (MemAddr=dst+i, write buffer) for i=0..N-1, in ascending order; DONE SHALL be at T+2N+1.
REQ-024 Fill of N>0 bytes SHALL stay in FL_WR for N cycles, writing data to dst+i; DONE SHALL be at T+N+1.
REQ-025 Copy/fill with ReqLen=0 SHALL go directly to DONE at T+1 with no memory access.
REQ-026 Address arithmetic SHALL be modulo 2**A; src+i and dst+i SHALL wrap from 2**A-1 to 0.
REQ-027 Overlapping copy regions SHALL execute strictly byte-serial ascending; with dst=src+1 the first source byte SHALL propagate into every destination byte.
REQ-028 DONE SHALL assert RespValid for exactly one cycle and return to IDLE; a new request SHALL NOT be accepted before that IDLE cycle.
REQ-029 RespData SHALL change only on load completion and SHALL hold its value through all other operations.
REQ-030 MemWriteEn SHALL be 1 only in ST, CP_WR and FL_WR; MemAddr and MemWData SHALL be 0 in IDLE and DONE.
REQ-031 Invalid or dropped ReqValid while not IDLE SHALL be ignored; no request SHALL be queued.

Reset
REQ-032 When Reset is high, the unit SHALL enter IDLE on the next edge and clear RespData, RespValid, Busy, the counter and the buffer to 0.
REQ-033 MemWriteEn SHALL be forced to 0 combinationally during any cycle in which Reset is high, including mid-copy/fill; writes completed earlier SHALL remain in memory.
REQ-034 ReqReady SHALL be 0 during Reset and 1 in the first cycle after Reset deasserts.

Verification
REQ-035 Preload memory [0x10]=0xA5; load addr 0x10 -> RespValid at T+2 with RespData=0xA5; MemWriteEn stays 0 throughout.
REQ-036 Store 0x3C to 0x20, then load 0x20 -> first RespValid at T+2, second load returns 0x3C; ReqReady=0 on both intermediate cycles.
REQ-037 Copy src=0xFE, dst=0x40, len=4 -> reads 0xFE,0xFF,0x00,0x01 and writes 0x40..0x43 in order; RespValid at T+9.
REQ-038 Fill dst=0xFD, val=0x77, len=5 -> memory 0xFD,0xFE,0xFF,0x00,0x01 hold 0x77; RespValid at T+6; len=0 -> RespValid at T+1 with no write.
REQ-039 Overlap copy src=0x50, dst=0x51, len=3, with [0x50]=0x11 -> 0x51..0x53 all 0x11.
REQ-040 Fill len=10 with Reset asserted at T+4 for one cycle -> exactly 3 bytes written, MemWriteEn=0 in the Reset cycle, state IDLE and ReqReady=1 in the following cycle, no RespValid.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit: load, store, byte-serial copy and fill
// against a single-port data memory with combinational read.
module mem_access_unit #(
   parameter int W = 8,
   parameter int A = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         ReqValid,
   output logic         ReqReady,
   input  logic [1:0]   ReqOp,
   input  logic [A-1:0] ReqAddr,
   input  logic [A-1:0] ReqSrc,
   input  logic [A-1:0] ReqLen,
   input  logic [W-1:0] ReqData,
   output logic         RespValid,
   output logic [W-1:0] RespData,
   output logic         Busy,
   output logic [A-1:0] MemAddr,
   output logic         MemWriteEn,
   output logic [W-1:0] MemWData,
   input  logic [W-1:0] MemRData
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LD    = 3'd1,
      S_ST    = 3'd2,
      S_CP_RD = 3'd3,
      S_CP_WR = 3'd4,
      S_FL_WR = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [1:0] OP_LD = 2'b00;
   localparam logic [1:0] OP_ST = 2'b01;
   localparam logic [1:0] OP_CP = 2'b10;
   localparam logic [1:0] OP_FL = 2'b11;

   state_t         r_state;
   logic [A-1:0]   r_addr;
   logic [A-1:0]   r_src;
   logic [A-1:0]   r_len;
   logic [W-1:0]   r_data;
   logic [A-1:0]   r_cnt;
   logic [W-1:0]   r_buf;
   logic [W-1:0]   r_rdata;

   logic           w_last;
   logic           w_len0;
   logic [A-1:0]   w_addr;
   logic           w_we;
   logic [W-1:0]   w_wdata;

   // last byte of a copy/fill is reached when the counter hits len-1
   assign w_last = (r_cnt == (r_len - A'(1)));
   assign w_len0 = (ReqLen == '0);

   // control FSM: accepts in IDLE, walks the byte counter, holds results
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_src   <= '0;
         r_len   <= '0;
         r_data  <= '0;
         r_cnt   <= '0;
         r_buf   <= '0;
         r_rdata <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (ReqValid) begin
                  r_addr <= ReqAddr;
                  r_src  <= ReqSrc;
                  r_len  <= ReqLen;
                  r_data <= ReqData;
                  r_cnt  <= '0;
                  unique case (ReqOp)
                     OP_LD: r_state <= S_LD;
                     OP_ST: r_state <= S_ST;
                     OP_CP: r_state <= w_len0 ? S_DONE : S_CP_RD;
                     OP_FL: r_state <= w_len0 ? S_DONE : S_FL_WR;
                     default: r_state <= S_IDLE;
                  endcase
               end
            end
            S_LD: begin
               r_rdata <= MemRData;
               r_state <= S_DONE;
            end
            S_ST: begin
               r_state <= S_DONE;
            end
            S_CP_RD: begin
               r_buf   <= MemRData;
               r_state <= S_CP_WR;
            end
            S_CP_WR: begin
               if (w_last) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt   <= r_cnt + A'(1);
                  r_state <= S_CP_RD;
               end
            end
            S_FL_WR: begin
               if (w_last) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + A'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // memory port decode from the registered state; address wraps mod 2**A
   always_comb begin
      w_addr  = '0;
      w_we    = 1'b0;
      w_wdata = '0;
      unique case (r_state)
         S_LD: begin
            w_addr = r_addr;
         end
         S_ST: begin
            w_addr  = r_addr;
            w_we    = 1'b1;
            w_wdata = r_data;
         end
         S_CP_RD: begin
            w_addr = r_src + r_cnt;
         end
         S_CP_WR: begin
            w_addr  = r_addr + r_cnt;
            w_we    = 1'b1;
            w_wdata = r_buf;
         end
         S_FL_WR: begin
            w_addr  = r_addr + r_cnt;
            w_we    = 1'b1;
            w_wdata = r_data;
         end
         default: begin
            w_addr  = '0;
            w_we    = 1'b0;
            w_wdata = '0;
         end
      endcase
   end

   // reset gates the write strobe immediately, even mid-operation
   assign MemWriteEn = w_we & ~Reset;
   assign MemAddr    = w_addr;
   assign MemWData   = w_wdata;
   assign ReqReady   = (r_state == S_IDLE) & ~Reset;
   assign Busy       = (r_state != S_IDLE);
   assign RespValid  = (r_state == S_DONE);
   assign RespData   = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: memory model plus scoreboards
// for expected writes and expected responses.
module tb_mem_access_unit;

   logic       Clk;
   logic       Reset;
   logic       ReqValid;
   logic       ReqReady;
   logic [1:0] ReqOp;
   logic [7:0] ReqAddr;
   logic [7:0] ReqSrc;
   logic [7:0] ReqLen;
   logic [7:0] ReqData;
   logic       RespValid;
   logic [7:0] RespData;
   logic       Busy;
   logic [7:0] MemAddr;
   logic       MemWriteEn;
   logic [7:0] MemWData;
   logic [7:0] MemRData;

   logic [7:0] mem [0:255];
   logic       pl_en;
   logic [7:0] pl_a;
   logic [7:0] pl_d;

   int cyc;
   int n_chk;
   int n_err;
   logic [7:0] last_ld;

   typedef struct {
      int         cyc;
      logic [7:0] d;
   } resp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   resp_t q_resp[$];
   wr_t   q_wr[$];

   mem_access_unit #(.W(8), .A(8)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .ReqValid   (ReqValid),
      .ReqReady   (ReqReady),
      .ReqOp      (ReqOp),
      .ReqAddr    (ReqAddr),
      .ReqSrc     (ReqSrc),
      .ReqLen     (ReqLen),
      .ReqData    (ReqData),
      .RespValid  (RespValid),
      .RespData   (RespData),
      .Busy       (Busy),
      .MemAddr    (MemAddr),
      .MemWriteEn (MemWriteEn),
      .MemWData   (MemWData),
      .MemRData   (MemRData)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   assign MemRData = mem[MemAddr];

   always @(posedge Clk) begin
      if (pl_en) mem[pl_a] <= pl_d;
      else if (MemWriteEn) mem[MemAddr] <= MemWData;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // monitor: pop scoreboards on every write strobe and response
   always @(negedge Clk) begin
      if (!Reset) begin
         if (MemWriteEn) begin
            if (q_wr.size() == 0) begin
               chk("wr_unexp", {MemAddr, MemWData}, 0);
            end else begin
               wr_t w;
               w = q_wr.pop_front();
               chk("wr_addr", MemAddr, w.a);
               chk("wr_data", MemWData, w.d);
            end
         end
         if (RespValid) begin
            if (q_resp.size() == 0) begin
               chk("resp_unexp", RespValid, 0);
            end else begin
               resp_t r;
               r = q_resp.pop_front();
               chk("resp_cyc", cyc, r.cyc);
               chk("resp_data", RespData, r.d);
               chk("done_port", {MemAddr, MemWData}, 0);
            end
         end
      end
   end

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pl_en = 1'b1;
      pl_a  = a;
      pl_d  = d;
      @(posedge Clk);
      #1;
      pl_en = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] addr,
                        input logic [7:0] src, input logic [7:0] len,
                        input logic [7:0] data, input bit noise,
                        output int t);
      @(posedge Clk);
      #1;
      ReqOp    = op;
      ReqAddr  = addr;
      ReqSrc   = src;
      ReqLen   = len;
      ReqData  = data;
      ReqValid = 1'b1;
      t = cyc;
      @(negedge Clk);
      chk("acc_ready", ReqReady, 1);
      @(posedge Clk);
      #1;
      if (noise) begin
         ReqOp   = 2'b01;
         ReqAddr = 8'hEE;
         ReqData = 8'hDD;
         @(posedge Clk);
         #1;
      end
      ReqValid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      forever begin
         @(negedge Clk);
         if (!Busy && q_resp.size() == 0) break;
         if (Busy) chk("busy_ready", ReqReady, 0);
         k++;
         if (k > 600) begin
            chk("timeout", 1, 0);
            break;
         end
      end
   endtask

   task automatic exp_resp(input int c, input logic [7:0] d);
      resp_t r;
      r.cyc = c;
      r.d   = d;
      q_resp.push_back(r);
   endtask

   task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      q_wr.push_back(w);
   endtask

   initial begin
      int t;
      logic [7:0] a;
      cyc      = 0;
      n_chk    = 0;
      n_err    = 0;
      last_ld  = 8'h00;
      Reset    = 1'b1;
      ReqValid = 1'b0;
      ReqOp    = '0;
      ReqAddr  = '0;
      ReqSrc   = '0;
      ReqLen   = '0;
      ReqData  = '0;
      pl_en    = 1'b0;
      pl_a     = '0;
      pl_d     = '0;
      @(posedge Clk);
      #1;
      for (int i = 0; i < 256; i++) preload(8'(i), 8'h00);
      preload(8'h10, 8'hA5);
      preload(8'h50, 8'h11);
      preload(8'hFE, 8'hB1);
      preload(8'hFF, 8'hB2);
      preload(8'h00, 8'hB3);
      preload(8'h01, 8'hB4);
      @(negedge Clk);
      chk("rst_ready", ReqReady, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_we", MemWriteEn, 0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(negedge Clk);
      chk("post_rst_ready", ReqReady, 1);
      chk("post_rst_busy", Busy, 0);
      chk("post_rst_rv", RespValid, 0);
      chk("post_rst_rd", RespData, 0);
      chk("idle_port", {MemAddr, MemWData}, 0);

      // load with a stray request held during busy
      issue(2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, t);
      last_ld = 8'hA5;
      exp_resp(t + 2, last_ld);
      wait_idle();

      // store then load back
      issue(2'b01, 8'h20, 8'h00, 8'h00, 8'h3C, 1'b0, t);
      exp_wr(8'h20, 8'h3C);
      exp_resp(t + 2, last_ld);
      wait_idle();
      issue(2'b00, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0, t);
      last_ld = 8'h3C;
      exp_resp(t + 2, last_ld);
      wait_idle();

      // copy across the address wrap
      issue(2'b10, 8'h40, 8'hFE, 8'd4, 8'h00, 1'b0, t);
      exp_wr(8'h40, 8'hB1);
      exp_wr(8'h41, 8'hB2);
      exp_wr(8'h42, 8'hB3);
      exp_wr(8'h43, 8'hB4);
      exp_resp(t + 9, last_ld);
      wait_idle();

      // fill across the address wrap
      issue(2'b11, 8'hFD, 8'h00, 8'd5, 8'h77, 1'b0, t);
      for (int i = 0; i < 5; i++) exp_wr(8'hFD + 8'(i), 8'h77);
      exp_resp(t + 6, last_ld);
      wait_idle();
      for (int i = 0; i < 5; i++) begin
         a = 8'hFD + 8'(i);
         chk("fill_mem", mem[a], 8'h77);
      end

      // zero-length fill and copy
      issue(2'b11, 8'h60, 8'h00, 8'd0, 8'h99, 1'b0, t);
      exp_resp(t + 1, last_ld);
      wait_idle();
      issue(2'b10, 8'h61, 8'h10, 8'd0, 8'h00, 1'b0, t);
      exp_resp(t + 1, last_ld);
      wait_idle();
      chk("len0_mem", mem[8'h60], 8'h00);

      // overlapping copy propagates the first byte
      issue(2'b10, 8'h51, 8'h50, 8'd3, 8'h00, 1'b0, t);
      exp_wr(8'h51, 8'h11);
      exp_wr(8'h52, 8'h11);
      exp_wr(8'h53, 8'h11);
      exp_resp(t + 7, last_ld);
      wait_idle();
      issue(2'b00, 8'h53, 8'h00, 8'h00, 8'h00, 1'b0, t);
      last_ld = 8'h11;
      exp_resp(t + 2, last_ld);
      wait_idle();

      // reset in the middle of a long fill
      issue(2'b11, 8'h80, 8'h00, 8'd10, 8'h5A, 1'b0, t);
      exp_wr(8'h80, 8'h5A);
      exp_wr(8'h81, 8'h5A);
      exp_wr(8'h82, 8'h5A);
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b1;
      @(negedge Clk);
      chk("rst_mid_we", MemWriteEn, 0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(negedge Clk);
      chk("rst_mid_ready", ReqReady, 1);
      chk("rst_mid_busy", Busy, 0);
      chk("rst_mid_rv", RespValid, 0);
      chk("rst_mid_rd", RespData, 0);
      repeat (4) @(negedge Clk);
      chk("rst_mid_m82", mem[8'h82], 8'h5A);
      chk("rst_mid_m83", mem[8'h83], 8'h00);
      chk("wr_q_empty", q_wr.size(), 0);
      chk("resp_q_empty", q_resp.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
